lsu_byte_serial: RTL and testbench

- Load/store unit sitting directly downstream of the multi-cycle control FSM, between its READ_MEMORY/WRITE_MEMORY states and the byte-wide RAM port.
- Converts one 8/16/32-bit RISC-V load or store into a sequence of single-byte RAM accesses.
- On loads, assembles the bytes little-endian and zero- or sign-extends the result to 32 bits.
- Uses a start/busy/done handshake, so the control FSM stalls on busy exactly as it does on alu_busy.

---
 rtl/lsu_byte_serial_pkg.sv | 21 ++
 rtl/lsu_byte_serial_load_extend.sv | 24 ++
 rtl/lsu_byte_serial.sv | 103 ++++++++++
 tb/tb_lsu_byte_serial.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lsu_byte_serial_pkg.sv
// lsu_byte_serial_pkg: shared types and helpers for the byte-serial load/store unit
package lsu_byte_serial_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } MemWidth;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } LsuState;

   // Encoding 3 is treated as a word access
   function automatic int unsigned width_to_nbytes(MemWidth w);
      return (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
   endfunction

endpackage

// File: rtl/lsu_byte_serial_load_extend.sv
// lsu_byte_serial_load_extend: zero/sign extension of an assembled little-endian load
module lsu_byte_serial_load_extend
   import lsu_byte_serial_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_raw,
   input  logic [1:0]      i_width,
   input  logic            i_is_unsigned,
   output logic [XLEN-1:0] o_extended
);

   logic w_msb;
   logic w_fill;

   // Replicate the top fetched byte's msb (or zero) above the loaded bytes
   always_comb begin
      w_msb      = (i_width == BYTE) ? i_raw[7] : i_raw[15];
      w_fill     = ~i_is_unsigned & w_msb;
      o_extended = (i_width == BYTE) ? {{(XLEN-8){w_fill}}, i_raw[7:0]} :
                   (i_width == HALF) ? {{(XLEN-16){w_fill}}, i_raw[15:0]} : i_raw;
   end

endmodule

// File: rtl/lsu_byte_serial.sv
// lsu_byte_serial: turns one 8/16/32-bit load or store into single-byte RAM accesses
module lsu_byte_serial
   import lsu_byte_serial_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_is_write,
   input  logic [1:0]        i_width,
   input  logic              i_is_unsigned,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [XLEN-1:0]   i_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic [XLEN-1:0]   o_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [7:0]        o_mem_wdata,
   input  logic [7:0]        i_mem_rdata
);

   localparam int NB = XLEN / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   LsuState           r_state;
   LsuState           w_next;
   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     r_last;
   logic [ADDR_W-1:0] r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_raw;
   logic              r_is_write;
   // width/signedness are captured only by loads so a store never disturbs rdata
   logic [1:0]        r_width;
   logic              r_is_unsigned;
   logic              w_start;
   logic              w_xfer;
   logic              w_last;

   assign w_start = (r_state == IDLE) && i_start;
   assign w_xfer  = (r_state == XFER);
   assign w_last  = (r_idx == r_last);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next state: start only matters in IDLE, DONE always returns to IDLE
   always_comb begin
      w_next = (r_state == IDLE) ? (i_start ? XFER : IDLE) :
               (r_state == XFER) ? (w_last ? DONE : XFER) : IDLE;
   end

   // Outputs: RAM port is driven only during XFER, otherwise held at zero
   always_comb begin
      o_busy      = (r_state != IDLE);
      o_done      = (r_state == DONE);
      o_mem_we    = w_xfer & r_is_write;
      o_mem_addr  = w_xfer ? r_addr + ADDR_W'(r_idx) : '0;
      o_mem_wdata = w_xfer ? r_wdata[8*r_idx +: 8] : '0;
   end

   // Request latch, byte index walk and little-endian load assembly
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx         <= '0;
         r_last        <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_raw         <= '0;
         r_is_write    <= 1'b0;
         r_width       <= 2'd0;
         r_is_unsigned <= 1'b0;
      end else if (w_start) begin
         r_idx      <= '0;
         r_last     <= IW'(width_to_nbytes(MemWidth'(i_width)) - 1);
         r_addr     <= i_addr;
         r_wdata    <= i_wdata;
         r_is_write <= i_is_write;
         if (!i_is_write) begin
            r_raw         <= '0;
            r_width       <= i_width;
            r_is_unsigned <= i_is_unsigned;
         end
      end else if (w_xfer) begin
         if (!r_is_write) r_raw[8*r_idx +: 8] <= i_mem_rdata;
         if (!w_last) r_idx <= r_idx + 1'b1;
      end
   end

   lsu_byte_serial_load_extend #(.XLEN(XLEN)) u_load_extend (
      .i_raw        (r_raw),
      .i_width      (r_width),
      .i_is_unsigned(r_is_unsigned),
      .o_extended   (o_rdata)
   );

endmodule

// File: tb/tb_lsu_byte_serial.sv
// tb_lsu_byte_serial: directed checks of the byte-serial load/store unit against a small RAM
module tb_lsu_byte_serial;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_write = 1'b0;
   logic [1:0]  width = 2'd0;
   logic        is_unsigned = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  ram [256];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_busy, n_done, done_at, n_we, n_log;
   logic [31:0] alog [8];

   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_addr[7:0]];

   always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;

   lsu_byte_serial dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_is_write   (is_write),
      .i_width      (width),
      .i_is_unsigned(is_unsigned),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_busy       (busy),
      .o_done       (done),
      .o_rdata      (rdata),
      .o_mem_addr   (mem_addr),
      .o_mem_we     (mem_we),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request, scramble the inputs afterwards, and watch 12 cycles
   task automatic do_op(input logic wr, input logic [1:0] w, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic restart);
      @(negedge clk);
      start = 1'b1; is_write = wr; width = w; is_unsigned = uns; addr = a; wdata = d;
      @(posedge clk);
      #1;
      start = 1'b0; is_write = ~wr; width = 2'd0; is_unsigned = ~uns; addr = 32'h10; wdata = 32'h5A5A5A5A;
      n_busy = 0; n_done = 0; done_at = 0; n_we = 0; n_log = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (restart && k == 2) begin
            start = 1'b1; is_write = 1'b0; width = 2'd0; addr = 32'h10;
         end
         if (restart && k == 3) start = 1'b0;
         if (busy) n_busy++;
         if (mem_we) n_we++;
         if (done) begin
            n_done++;
            if (done_at == 0) done_at = k;
         end
         if (busy && !done && n_log < 8) begin
            alog[n_log] = mem_addr;
            n_log++;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      ram[8'h80] = 8'h58; ram[8'h81] = 8'h00; ram[8'h82] = 8'h00; ram[8'h83] = 8'h80;
      ram[8'h10] = 8'hF3;
      ram[8'h78] = 8'h11; ram[8'h79] = 8'h22; ram[8'h7A] = 8'h33; ram[8'h7B] = 8'h44;
      ram[8'hFE] = 8'hA1; ram[8'hFF] = 8'hB2; ram[8'h00] = 8'hC3; ram[8'h01] = 8'hD4;

      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_maddr", mem_addr, 32'd0);
      check("rst_mwdata", 32'(mem_wdata), 32'd0);
      rst_n = 1'b1;

      do_op(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 1'b0);
      check("wl_busy", 32'(n_busy), 32'd5);
      check("wl_done_at", 32'(done_at), 32'd5);
      check("wl_ndone", 32'(n_done), 32'd1);
      check("wl_we", 32'(n_we), 32'd0);
      check("wl_addr3", alog[3], 32'h83);
      check("wl_rdata", rdata, 32'h80000058);

      do_op(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0);
      check("bs_done_at", 32'(done_at), 32'd2);
      check("bs_busy", 32'(n_busy), 32'd2);
      check("bs_rdata", rdata, 32'hFFFFFFF3);

      do_op(1'b0, 2'd1, 1'b0, 32'h82, 32'h0, 1'b0);
      check("hs_done_at", 32'(done_at), 32'd3);
      check("hs_rdata", rdata, 32'hFFFF8000);

      do_op(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0);
      check("bu_rdata", rdata, 32'h000000F3);

      do_op(1'b1, 2'd1, 1'b0, 32'h79, 32'h1234ABCD, 1'b0);
      check("st_we", 32'(n_we), 32'd2);
      check("st_done_at", 32'(done_at), 32'd3);
      check("st_addr0", alog[0], 32'h79);
      check("st_addr1", alog[1], 32'h7A);
      check("st_ram79", 32'(ram[8'h79]), 32'hCD);
      check("st_ram7a", 32'(ram[8'h7A]), 32'hAB);
      check("st_ram78", 32'(ram[8'h78]), 32'h11);
      check("st_ram7b", 32'(ram[8'h7B]), 32'h44);
      check("st_rdata", rdata, 32'h000000F3);

      do_op(1'b0, 2'd3, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0);
      check("wr_addr0", alog[0], 32'hFFFFFFFE);
      check("wr_addr1", alog[1], 32'hFFFFFFFF);
      check("wr_addr2", alog[2], 32'h00000000);
      check("wr_addr3", alog[3], 32'h00000001);
      check("wr_rdata", rdata, 32'hD4C3B2A1);

      do_op(1'b0, 2'd2, 1'b1, 32'h80, 32'h0, 1'b1);
      check("ig_ndone", 32'(n_done), 32'd1);
      check("ig_done_at", 32'(done_at), 32'd5);
      check("ig_addr0", alog[0], 32'h80);
      check("ig_rdata", rdata, 32'h80000058);

      @(negedge clk);
      start = 1'b1; is_write = 1'b1; width = 2'd2; addr = 32'h78; wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check("rm_we_pre", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rm_busy", 32'(busy), 32'd0);
      check("rm_done", 32'(done), 32'd0);
      check("rm_we", 32'(mem_we), 32'd0);
      check("rm_rdata", rdata, 32'd0);
      n_we = 0; n_done = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 1) rst_n = 1'b1;
         if (mem_we) n_we++;
         if (done) n_done++;
      end
      check("rm_we_after", 32'(n_we), 32'd0);
      check("rm_done_after", 32'(n_done), 32'd0);
      check("rm_ram78", 32'(ram[8'h78]), 32'h0D);
      check("rm_ram79", 32'(ram[8'h79]), 32'hF0);
      check("rm_ram7a", 32'(ram[8'h7A]), 32'hAB);
      check("rm_ram7b", 32'(ram[8'h7B]), 32'h44);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
